// File: rtl/demux_dest_buf.sv
// Destination demux feeding one first-word-fall-through FIFO per output channel.
// The word is routed by dest_in and each channel is drained independently through pop[k].

module demux_dest_buf_chan #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH),
    parameter int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W:0]   wdata_i,
    output logic [DATA_W:0]   head_o,
    output logic [CW-1:0]     count_o
);
    logic [DATA_W:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_pop;

    // push_i arrives already qualified against full, so only pop needs gating here
    assign do_pop = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
endmodule

module demux_dest_buf #(
    parameter int DATA_W = 8,
    parameter int DEST_W = 1,
    parameter int DEPTH  = 4,
    parameter int N      = 1 << DEST_W,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [DATA_W-1:0]   data_in,
    input  logic [DEST_W-1:0]   dest_in,
    input  logic                class_in,
    output logic                ready_in,
    input  logic [N-1:0]        pop,
    output logic [N*DATA_W-1:0] data_out,
    output logic [N-1:0]        class_out,
    output logic [N-1:0]        valid_out,
    output logic [N-1:0]        full,
    output logic [N*CW-1:0]     count
);
    logic [N-1:0][DATA_W-1:0] data_w;
    logic [N-1:0][DATA_W:0]   head_w;
    logic [N-1:0][CW-1:0]     cnt_w;
    logic [N-1:0]             push_w;

    assign ready_in = ~full[dest_in];

    for (genvar g = 0; g < N; g++) begin : g_chan
        assign push_w[g] = valid_in && ready_in && (dest_in == DEST_W'(g));

        demux_dest_buf_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .push_i  (push_w[g]),
            .pop_i   (pop[g]),
            .wdata_i ({class_in, data_in}),
            .head_o  (head_w[g]),
            .count_o (cnt_w[g])
        );

        assign data_w[g]    = head_w[g][DATA_W-1:0];
        assign class_out[g] = head_w[g][DATA_W];
        assign full[g]      = (cnt_w[g] == CW'(DEPTH));
        assign valid_out[g] = (cnt_w[g] != '0);
    end

    assign data_out = data_w;
    assign count    = cnt_w;
endmodule

// File: tb/tb_demux_dest_buf.sv
// Bench for demux_dest_buf (DATA_W=8, DEST_W=1, DEPTH=4): directed scenarios plus
// randomized traffic compared against per-channel queue reference model.

module tb_demux_dest_buf;
    logic        clk, reset, valid_in, class_in, ready_in;
    logic [7:0]  data_in;
    logic [0:0]  dest_in;
    logic [1:0]  pop, class_out, valid_out, full;
    logic [15:0] data_out;
    logic [5:0]  count;

    int checks = 0;
    int errors = 0;
    logic [8:0] mq [2][$];

    demux_dest_buf #(.DATA_W(8), .DEST_W(1), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .dest_in(dest_in), .class_in(class_in), .ready_in(ready_in), .pop(pop),
        .data_out(data_out), .class_out(class_out), .valid_out(valid_out),
        .full(full), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, updating the reference queues from the inputs presented before it
    task automatic tick();
        bit acc;
        acc = valid_in && (mq[dest_in].size() < 4);
        for (int k = 0; k < 2; k++)
            if (pop[k] && mq[k].size() > 0) void'(mq[k].pop_front());
        if (acc) mq[dest_in].push_back({class_in, data_in});
        @(posedge clk); #1;
    endtask

    task automatic drive(input bit v, input logic [0:0] d, input logic [7:0] w, input bit c, input logic [1:0] p);
        valid_in = v; dest_in = d; data_in = w; class_in = c; pop = p;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 8'h00, 0, 2'b00);
        #2;
        checks++;
        if (valid_out !== 2'b00 || full !== 2'b00 || count !== 6'd0 || ready_in !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid_out=%b full=%b count=%h ready_in=%b, want 00 00 00 1",
                     valid_out, full, count, ready_in);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_routing();
        drive(1, 1, 8'h0F, 1, 2'b00); tick();
        drive(1, 0, 8'h01, 0, 2'b00); tick();
        drive(0, 0, 8'h00, 0, 2'b00);
        checks++;
        if (valid_out !== 2'b11 || data_out !== 16'h0F01 || count !== {3'd1, 3'd1} || class_out !== 2'b10) begin
            errors++;
            $display("FAIL routing: valid_out=%b data_out=%h count=%h class_out=%b, want 11 0f01 09 10",
                     valid_out, data_out, count, class_out);
        end
        pop = 2'b11; tick(); pop = 2'b00;
        checks++;
        if (valid_out !== 2'b00) begin
            errors++;
            $display("FAIL routing_drain: valid_out=%b want 00", valid_out);
        end
    endtask

    task automatic test_fill_backpressure();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'h10 + 8'(i), 0, 2'b00); tick();
        end
        checks++;
        if (full !== 2'b01 || count[2:0] !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: full=%b count0=%0d, want 01 4", full, count[2:0]);
        end
        drive(1, 0, 8'h14, 1, 2'b00); #1;
        checks++;
        if (ready_in !== 1'b0) begin
            errors++;
            $display("FAIL fill_ready0: ready_in=%b want 0", ready_in);
        end
        tick();
        checks++;
        if (count[2:0] !== 3'd4 || data_out[7:0] !== 8'h10) begin
            errors++;
            $display("FAIL fill_held: count0=%0d head0=%h, want 4 10", count[2:0], data_out[7:0]);
        end
        dest_in = 1'b1; #1;
        checks++;
        if (ready_in !== 1'b1) begin
            errors++;
            $display("FAIL fill_ready1: ready_in=%b want 1", ready_in);
        end
        tick();
        drive(0, 0, 8'h00, 0, 2'b00);
        checks++;
        if (count[5:3] !== 3'd1 || data_out[15:8] !== 8'h14 || class_out[1] !== 1'b1) begin
            errors++;
            $display("FAIL fill_ch1: count1=%0d head1=%h class1=%b, want 1 14 1",
                     count[5:3], data_out[15:8], class_out[1]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out[7:0] !== 8'h10 + 8'(i)) begin
                errors++;
                $display("FAIL fill_order: head0=%h want %h", data_out[7:0], 8'h10 + 8'(i));
            end
            pop = (i == 0) ? 2'b11 : 2'b01; tick();
        end
        pop = 2'b00;
        checks++;
        if (valid_out !== 2'b00) begin
            errors++;
            $display("FAIL fill_drain: valid_out=%b want 00", valid_out);
        end
    endtask

    task automatic test_wrap();
        int j = 0;
        int maxc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 8'hA0 + 8'(i), 0, (i >= 2) ? 2'b10 : 2'b00);
            if (i >= 2) begin
                checks++;
                if (data_out[15:8] !== 8'hA0 + 8'(j)) begin
                    errors++;
                    $display("FAIL wrap_order: head1=%h want %h", data_out[15:8], 8'hA0 + 8'(j));
                end
                j++;
            end
            tick();
            if (int'(count[5:3]) > maxc) maxc = int'(count[5:3]);
        end
        drive(0, 0, 8'h00, 0, 2'b10);
        for (int c = 0; c < 4 && valid_out[1]; c++) begin
            checks++;
            if (data_out[15:8] !== 8'hA0 + 8'(j)) begin
                errors++;
                $display("FAIL wrap_order: head1=%h want %h", data_out[15:8], 8'hA0 + 8'(j));
            end
            j++;
            tick();
        end
        pop = 2'b00;
        checks++;
        if (j != 6 || maxc > 2 || valid_out[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_total: popped=%0d maxcount=%0d valid1=%b, want 6 <=2 0", j, maxc, valid_out[1]);
        end
    endtask

    task automatic test_push_pop();
        drive(1, 0, 8'hB0, 0, 2'b00); tick();
        drive(1, 0, 8'hB1, 0, 2'b00); tick();
        drive(1, 0, 8'hB2, 0, 2'b01); tick();
        drive(0, 0, 8'h00, 0, 2'b00);
        checks++;
        if (count[2:0] !== 3'd2 || data_out[7:0] !== 8'hB1) begin
            errors++;
            $display("FAIL push_pop: count0=%0d head0=%h, want 2 b1", count[2:0], data_out[7:0]);
        end
        pop = 2'b01; tick(); tick(); pop = 2'b00;
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 8'hC0 + 8'(i), 0, 2'b00); tick();
        end
        drive(1, 0, 8'hC4, 0, 2'b01); tick();
        drive(0, 0, 8'h00, 0, 2'b00);
        checks++;
        if (count[2:0] !== 3'd3 || data_out[7:0] !== 8'hC1 || full[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: count0=%0d head0=%h full0=%b, want 3 c1 0", count[2:0], data_out[7:0], full[0]);
        end
    endtask

    task automatic test_midrun_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 8'hD0 + 8'(i), 0, 2'b00); tick();
        end
        checks++;
        if (count !== {3'd3, 3'd3}) begin
            errors++;
            $display("FAIL mid_pre: count=%h want 1b", count);
        end
        @(negedge clk);
        drive(1, 0, 8'hEE, 0, 2'b11);
        reset = 1'b1;
        #1;
        checks++;
        if (valid_out !== 2'b00 || count !== 6'd0 || ready_in !== 1'b1 || full !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: valid_out=%b count=%h ready_in=%b full=%b, want 00 00 1 00",
                     valid_out, count, ready_in, full);
        end
        mq[0].delete(); mq[1].delete();
        @(posedge clk); #1;
        checks++;
        if (valid_out !== 2'b00 || count !== 6'd0) begin
            errors++;
            $display("FAIL mid_hold: valid_out=%b count=%h, want 00 00", valid_out, count);
        end
        reset = 1'b0;
        drive(1, 0, 8'hE0, 1, 2'b00); tick();
        drive(0, 0, 8'h00, 0, 2'b00);
        checks++;
        if (valid_out !== 2'b01 || data_out[7:0] !== 8'hE0 || count !== 6'd1) begin
            errors++;
            $display("FAIL mid_resume: valid_out=%b head0=%h count=%h, want 01 e0 01",
                     valid_out, data_out[7:0], count);
        end
        pop = 2'b01; tick(); pop = 2'b00;
    endtask

    task automatic test_random();
        for (int n = 0; n < 500; n++) begin
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom), 8'($urandom), 1'($urandom),
                  ($urandom_range(0, 99) < 40) ? 2'($urandom) : 2'b00);
            #1;
            checks++;
            if (ready_in !== (mq[dest_in].size() < 4)) begin
                errors++;
                $display("FAIL rand_ready: cycle %0d ready_in=%b want %b", n, ready_in, mq[dest_in].size() < 4);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (valid_out[k] !== (mq[k].size() != 0) || full[k] !== (mq[k].size() == 4) ||
                    count[k*3 +: 3] !== 3'(mq[k].size()) ||
                    (mq[k].size() != 0 && {class_out[k], data_out[k*8 +: 8]} !== mq[k][0])) begin
                    errors++;
                    $display("FAIL rand_chan%0d: cycle %0d valid=%b full=%b count=%0d head=%h, want size %0d head %h",
                             k, n, valid_out[k], full[k], count[k*3 +: 3], {class_out[k], data_out[k*8 +: 8]},
                             mq[k].size(), (mq[k].size() != 0) ? mq[k][0] : 9'h0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_fill_backpressure();
        test_wrap();
        test_push_pop();
        test_full_pop();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
